// File: rtl/dash_game_ctrl.sv
// dash_game_ctrl: Mario-Dash game sequencer owning game state, level, lava hazards and respawn.
// Define DASH_LAVA_WALL_EN to build the advancing side lava wall; otherwise it is parked off-screen.
module dash_game_ctrl #(
  parameter int WALL_DIV     = 4,
  parameter int WALL_STEP    = 1,
  parameter int RISE_DIV     = 2,
  parameter int LAVA_MAX     = 200,
  parameter int CLEAR_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [2:0] game_state,
  output logic [1:0] level,
  output logic [9:0] lava_wall_x,
  output logic [9:0] lava_height,
  output logic       respawn
);
  typedef enum logic [2:0] {
    RUNNING     = 3'd0,
    GAME_OVER   = 3'd1,
    WIN         = 3'd2,
    LEVEL_CLEAR = 3'd3
  } state_t;

  localparam int RC_W = (RISE_DIV > 1) ? $clog2(RISE_DIV) : 1;
  localparam int CC_W = (CLEAR_FRAMES > 1) ? $clog2(CLEAR_FRAMES) : 1;

  if (WALL_DIV < 1 || WALL_STEP < 1 || RISE_DIV < 1 || CLEAR_FRAMES < 1) begin : g_bad_param
    $error("dash_game_ctrl: dividers, step and clear length must be at least 1");
  end

  function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [10:0] inc,
                                         input logic [10:0] lim);
    logic [10:0] sum;
    sum = {1'b0, a} + inc;
    return (sum > lim) ? lim[9:0] : sum[9:0];
  endfunction

  state_t          state_q, state_d;
  logic            level_q, level_d;
  logic [9:0]      height_q, height_d;
  logic [RC_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [CC_W-1:0] clear_cnt_q, clear_cnt_d;
  logic            pend_q, respawn_q;
  logic            advance, restart;

  logic [10:0] bot, cx, lava_top;
  logic        band_hit, water_hit, wall_hit, lose, goal;

  assign bot      = {1'b0, player_y} + 11'd16;
  assign cx       = {1'b0, player_x} + 11'd8;
  assign lava_top = 11'd480 - {1'b0, height_q};
  assign band_hit = (cx >= 11'd270) && (cx <= 11'd309) && (bot > lava_top);
  assign water_hit = (bot > 11'd400) &&
                     (((cx > 11'd100) && (cx < 11'd200)) ||
                      ((cx > 11'd300) && (cx < 11'd400)) ||
                      ((cx > 11'd500) && (cx < 11'd550)));
  assign lose = level_q ? (water_hit || band_hit)
                        : ((bot > 11'd380) || wall_hit || band_hit);
  assign goal = level_q ? ((player_x >= 10'd600) && (bot <= 11'd400))
                        : ((player_x >= 10'd580) && (bot >= 11'd352) && (bot <= 11'd360));

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    clear_cnt_d = clear_cnt_q;
    advance     = 1'b0;
    restart     = 1'b0;
    case (state_q)
      RUNNING: begin
        if (frame_tick) begin
          if (lose)      state_d = GAME_OVER;
          else if (goal) state_d = level_q ? WIN : LEVEL_CLEAR;
          else           advance = 1'b1;
        end
      end
      GAME_OVER: begin
        if (start) begin
          restart = 1'b1;
          state_d = RUNNING;
        end
      end
      WIN: begin
        if (start) begin
          restart = 1'b1;
          level_d = 1'b0;
          state_d = RUNNING;
        end
      end
      LEVEL_CLEAR: begin
        if (frame_tick) begin
          if (clear_cnt_q == CC_W'(CLEAR_FRAMES - 1)) begin
            restart = 1'b1;
            level_d = 1'b1;
            state_d = RUNNING;
          end else begin
            clear_cnt_d = clear_cnt_q + CC_W'(1);
          end
        end
      end
      default: state_d = RUNNING;
    endcase
    if (restart) clear_cnt_d = '0;
  end

  // Rising lava band: moves in both levels, frozen outside RUNNING
  always_comb begin
    rise_cnt_d = rise_cnt_q;
    height_d   = height_q;
    if (restart) begin
      rise_cnt_d = '0;
      height_d   = '0;
    end else if (advance) begin
      if (rise_cnt_q == RC_W'(RISE_DIV - 1)) begin
        rise_cnt_d = '0;
        height_d   = sat_add(height_q, 11'd1, 11'(LAVA_MAX));
      end else begin
        rise_cnt_d = rise_cnt_q + RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUNNING;
      level_q     <= 1'b0;
      height_q    <= '0;
      rise_cnt_q  <= '0;
      clear_cnt_q <= '0;
      pend_q      <= 1'b1;
      respawn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      height_q    <= height_d;
      rise_cnt_q  <= rise_cnt_d;
      clear_cnt_q <= clear_cnt_d;
      pend_q      <= 1'b0;
      respawn_q   <= pend_q | restart;
    end
  end

`ifdef DASH_LAVA_WALL_EN
  localparam int WC_W = (WALL_DIV > 1) ? $clog2(WALL_DIV) : 1;

  logic [WC_W-1:0] wall_cnt_q, wall_cnt_d;
  logic [9:0]      wall_q, wall_d;

  assign wall_hit = {1'b0, player_x} < ({1'b0, wall_q} + 11'd10);

  // Wall counter runs in both levels but the wall only steps in level 0
  always_comb begin
    wall_cnt_d = wall_cnt_q;
    wall_d     = wall_q;
    if (restart) begin
      wall_cnt_d = '0;
      wall_d     = '0;
    end else if (advance) begin
      if (wall_cnt_q == WC_W'(WALL_DIV - 1)) begin
        wall_cnt_d = '0;
        if (!level_q) wall_d = sat_add(wall_q, 11'(WALL_STEP), 11'd630);
      end else begin
        wall_cnt_d = wall_cnt_q + WC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wall_cnt_q <= '0;
      wall_q     <= '0;
    end else begin
      wall_cnt_q <= wall_cnt_d;
      wall_q     <= wall_d;
    end
  end

  assign lava_wall_x = wall_q;
`else
  assign wall_hit    = 1'b0;
  assign lava_wall_x = 10'd1023;
`endif

  assign game_state = state_q;
  assign level      = {1'b0, level_q};
  assign lava_height = height_q;
  assign respawn    = respawn_q;

endmodule

// File: tb/tb_dash_game_ctrl.sv
// Bench for dash_game_ctrl: directed steps plus random play checked against a frame-count model.
module tb_dash_game_ctrl;
  localparam int WALL_DIV     = 4;
  localparam int WALL_STEP    = 1;
  localparam int RISE_DIV     = 2;
  localparam int LAVA_MAX     = 200;
  localparam int CLEAR_FRAMES = 120;
`ifdef DASH_LAVA_WALL_EN
  localparam bit WALL_EN = 1'b1;
`else
  localparam bit WALL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] player_x = 10'd100;
  logic [9:0] player_y = 10'd340;
  logic [2:0] game_state;
  logic [1:0] level;
  logic [9:0] lava_wall_x;
  logic [9:0] lava_height;
  logic       respawn;

  int compared = 0;
  int mismatched = 0;

  // Reference model: state name code, level, ticks advanced since restart, ticks spent clearing
  int m_state, m_level, m_run, m_clear;
  bit m_resp, m_pend;

  dash_game_ctrl #(
    .WALL_DIV(WALL_DIV), .WALL_STEP(WALL_STEP), .RISE_DIV(RISE_DIV),
    .LAVA_MAX(LAVA_MAX), .CLEAR_FRAMES(CLEAR_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .player_x(player_x), .player_y(player_y),
    .game_state(game_state), .level(level), .lava_wall_x(lava_wall_x),
    .lava_height(lava_height), .respawn(respawn)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_wall();
    int w;
    if (!WALL_EN) return 1023;
    if (m_level != 0) return 0;
    w = (m_run / WALL_DIV) * WALL_STEP;
    return (w > 630) ? 630 : w;
  endfunction

  function automatic int exp_height();
    int h;
    h = m_run / RISE_DIV;
    return (h > LAVA_MAX) ? LAVA_MAX : h;
  endfunction

  function automatic bit model_lose(input int px, input int py);
    int bot, cx;
    bit band;
    bot  = py + 16;
    cx   = px + 8;
    band = (cx >= 270) && (cx <= 309) && (bot > 480 - exp_height());
    if (m_level == 0)
      return (bot > 380) || (WALL_EN && (px < exp_wall() + 10)) || band;
    return ((bot > 400) && (((cx > 100) && (cx < 200)) || ((cx > 300) && (cx < 400)) ||
                            ((cx > 500) && (cx < 550)))) || band;
  endfunction

  function automatic bit model_goal(input int px, input int py);
    int bot;
    bot = py + 16;
    if (m_level == 0) return (px >= 580) && (bot >= 352) && (bot <= 360);
    return (px >= 600) && (bot <= 400);
  endfunction

  function automatic void model_reset();
    m_state = 0; m_level = 0; m_run = 0; m_clear = 0; m_resp = 0; m_pend = 1;
  endfunction

  function automatic void model_edge(input bit tk, input bit st, input int px, input int py);
    bit rs;
    bit lz, gl;
    rs = 0;
    lz = model_lose(px, py);
    gl = model_goal(px, py);
    m_resp = m_pend;
    m_pend = 0;
    case (m_state)
      0: if (tk) begin
           if (lz) m_state = 1;
           else if (gl) m_state = (m_level == 0) ? 3 : 2;
           else m_run++;
         end
      1: if (st) rs = 1;
      2: if (st) begin m_level = 0; rs = 1; end
      3: if (tk) begin
           m_clear++;
           if (m_clear == CLEAR_FRAMES) begin m_level = 1; rs = 1; end
         end
      default: ;
    endcase
    if (rs) begin m_state = 0; m_run = 0; m_clear = 0; m_resp = 1; end
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},   int'(game_state),  m_state);
    chk({tag, ".level"},   int'(level),       m_level);
    chk({tag, ".wall"},    int'(lava_wall_x), exp_wall());
    chk({tag, ".height"},  int'(lava_height), exp_height());
    chk({tag, ".respawn"}, int'(respawn),     int'(m_resp));
  endtask

  task automatic step(input string tag, input bit tk, input bit st);
    frame_tick = tk;
    start      = st;
    @(posedge clk);
    if (rst) model_edge(tk, st, int'(player_x), int'(player_y));
    #1;
    check_all(tag);
    frame_tick = 1'b0;
    start      = 1'b0;
  endtask

  task automatic place(input int px, input int py);
    player_x = 10'(px);
    player_y = 10'(py);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    step("first_edge", 1'b0, 1'b0);
    chk("first_edge.respawn_hi", int'(respawn), 1);
    step("second_edge", 1'b0, 1'b0);
    chk("second_edge.respawn_lo", int'(respawn), 0);

    // Eight frames in level 0 at a safe spot
    place(100, 340);
    for (int i = 0; i < 8; i++) begin
      step("run8", 1'b1, 1'b0);
      step("run8_gap", 1'b0, 1'b0);
    end
    chk("run8.wall_abs", int'(lava_wall_x), WALL_EN ? 2 : 1023);
    chk("run8.height_abs", int'(lava_height), 4);
    chk("run8.state_abs", int'(game_state), 0);

    // Fall into the lava floor, hazards freeze, then restart
    place(100, 370);
    step("floor", 1'b1, 1'b0);
    chk("floor.state_abs", int'(game_state), 1);
    step("frozen", 1'b1, 1'b0);
    chk("frozen.height_abs", int'(lava_height), 4);
    step("restart", 1'b0, 1'b1);
    chk("restart.respawn_abs", int'(respawn), 1);
    chk("restart.height_abs", int'(lava_height), 0);
    step("restart_after", 1'b0, 1'b0);

    // Level 0 goal, then 120 clear frames with start ignored
    place(590, 340);
    step("goal0", 1'b1, 1'b0);
    chk("goal0.state_abs", int'(game_state), 3);
    for (int i = 0; i < CLEAR_FRAMES - 1; i++) step("clearing", 1'b1, (i % 10) == 0);
    chk("clearing.state_abs", int'(game_state), 3);
    step("clear_done", 1'b1, 1'b0);
    chk("clear_done.level_abs", int'(level), 1);
    chk("clear_done.state_abs", int'(game_state), 0);
    chk("clear_done.respawn_abs", int'(respawn), 1);

    // Level 1 water, restart, then win and return to level 0
    place(150, 390);
    step("water", 1'b1, 1'b0);
    chk("water.state_abs", int'(game_state), 1);
    step("water_restart", 1'b0, 1'b1);
    chk("water_restart.level_abs", int'(level), 1);
    place(610, 384);
    step("win", 1'b1, 1'b0);
    chk("win.state_abs", int'(game_state), 2);
    step("win_tick", 1'b1, 1'b0);
    step("win_start", 1'b0, 1'b1);
    chk("win_start.level_abs", int'(level), 0);
    chk("win_start.state_abs", int'(game_state), 0);

`ifdef DASH_LAVA_WALL_EN
    // Let the wall saturate, then stand in the goal while overlapping it
    place(1000, 100);
    for (int i = 0; i < 2530; i++) step("wall_run", 1'b1, 1'b0);
    chk("wall_run.wall_abs", int'(lava_wall_x), 630);
    place(590, 340);
    step("goal_and_lose", 1'b1, 1'b0);
    chk("goal_and_lose.state_abs", int'(game_state), 1);
    step("goal_and_lose_restart", 1'b0, 1'b1);
`endif

    // Start and tick together in GAME_OVER: restart wins, tick discarded
    place(100, 370);
    step("go2", 1'b1, 1'b0);
    place(100, 340);
    step("go2_both", 1'b1, 1'b1);
    chk("go2_both.state_abs", int'(game_state), 0);
    chk("go2_both.height_abs", int'(lava_height), 0);
    step("go2_t1", 1'b1, 1'b0);
    step("go2_t2", 1'b1, 1'b0);
    chk("go2_t2.height_abs", int'(lava_height), 1);

    // Asynchronous reset in the middle of LEVEL_CLEAR
    place(590, 340);
    step("clear2", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("clear2_run", 1'b1, 1'b0);
    #3 rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst.state_abs", int'(game_state), 0);
    @(negedge clk);
    rst = 1'b1;
    step("async_rel", 1'b0, 1'b0);
    chk("async_rel.respawn_abs", int'(respawn), 1);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: place($urandom_range(0, 1023), $urandom_range(0, 1023));
        1: place($urandom_range(30, 250), $urandom_range(100, 300));
        2: place($urandom_range(575, 600), $urandom_range(334, 346));
        default: place($urandom_range(595, 625), $urandom_range(370, 390));
      endcase
      step("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
